// File: rtl/switch_debouncer_pkg.sv
// Shared types and default timing constants for the switch debouncer.
// Every per-bit debouncer and the multi-bit wrapper import this package.
package debounce_pkg;

   // A bit is STABLE while its synchronised input matches its debounced output.
   typedef enum logic {
      STABLE   = 1'b0,
      CHANGING = 1'b1
   } db_state_e;

   // 10 ms of stability at 50 MHz, and a counter width that can hold M-1.
   localparam int DB_M_50MHZ_10MS = 500000;
   localparam int DB_W            = 19;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus.
// The board side drives raw switch levels. The debouncer returns clean levels and edge pulses.
interface switch_debouncer_if #(
   parameter int N = 17
);
   logic [N-1:0] sw;
   logic [N-1:0] db;
   logic [N-1:0] rise;
   logic [N-1:0] fall;

   modport master (output sw, input db, input rise, input fall);
   modport slave  (input sw, output db, output rise, output fall);
endinterface

// File: rtl/debounce_bit.sv
// One debounced switch bit: a two-flop synchroniser, a stability counter,
// the debounced level register, and registered rise/fall pulses.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// STABLE   | s2 == db; counter held at 0
// CHANGING | s2 != db; counter advances, and db commits when it reaches M-1
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int M = DB_M_50MHZ_10MS,
   parameter int W = DB_W
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam logic [W-1:0] CNT_LAST = W'(M - 1);

   logic         s1_q;
   logic         s2_q;
   logic         db_q;
   logic         rise_q;
   logic         fall_q;
   logic [W-1:0] cnt_q;

   logic         db_d;
   logic         rise_d;
   logic         fall_d;
   logic [W-1:0] cnt_d;
   db_state_e    state;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= sw;
         s2_q   <= s1_q;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   // Any return of s2 to db clears the count: earlier stable cycles earn no credit.
   always_comb begin
      state  = (s2_q == db_q) ? STABLE : CHANGING;
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (state)
         STABLE: begin
            cnt_d = '0;
         end
         CHANGING: begin
            if (cnt_q == CNT_LAST) begin
               db_d   = s2_q;
               rise_d = s2_q;
               fall_d = ~s2_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      db   = db_q;
      rise = rise_q;
      fall = fall_q;
   end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer. Each of the N switch bits is synchronised and
// debounced on its own, with no interaction between bits.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int N = 17,
   parameter int M = DB_M_50MHZ_10MS,
   parameter int W = DB_W
) (
   input  logic               clk,
   input  logic               reset,
   switch_debouncer_if.slave  bus
);

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      debounce_bit #(
         .M (M),
         .W (W)
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .sw    (bus.sw[gi]),
         .db    (bus.db[gi]),
         .rise  (bus.rise[gi]),
         .fall  (bus.fall[gi])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (N=4, M=4, W=3).
// A window-of-M-samples reference model is checked against the DUT every cycle.
module tb_switch_debouncer;

   localparam int N = 4;
   localparam int M = 4;
   localparam int W = 3;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   switch_debouncer_if #(.N(N)) bus ();

   switch_debouncer #(
      .N (N),
      .M (M),
      .W (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Reference model: db flips to v once the synchronised input has read v for
   // the last M consecutive cycles while db still held the opposite value.
   logic [N-1:0] s1_m, s2_m, db_m, rise_m, fall_m, nd_m;
   logic [N-1:0] hist [$];
   bit           model_valid = 1'b0;
   bit           all_diff;

   always @(posedge clk) begin
      if (reset) begin
         s1_m   = '0;
         s2_m   = '0;
         db_m   = '0;
         rise_m = '0;
         fall_m = '0;
         hist.delete();
         hist.push_back('0);
         model_valid = 1'b1;
      end else if (model_valid) begin
         nd_m   = db_m;
         rise_m = '0;
         fall_m = '0;
         for (int i = 0; i < N; i++) begin
            all_diff = (hist.size() >= M);
            for (int j = 0; j < hist.size(); j++)
               if (hist[j][i] == db_m[i]) all_diff = 1'b0;
            if (all_diff) begin
               nd_m[i]   = ~db_m[i];
               rise_m[i] = ~db_m[i];
               fall_m[i] = db_m[i];
            end
         end
         db_m = nd_m;
         s2_m = s1_m;
         s1_m = bus.sw;
         hist.push_back(s2_m);
         if (hist.size() > M) void'(hist.pop_front());
      end
      #1;
      if (model_valid) begin
         chk("model_db", bus.db, db_m);
         chk("model_rise", bus.rise, rise_m);
         chk("model_fall", bus.fall, fall_m);
      end
   end

   task automatic edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v);
      @(negedge clk);
      bus.sw = v;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      bus.sw   = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Switches held high through reset
      for (int k = 1; k <= 5; k++) begin
         edges(1);
         chk("rst_db_low", bus.db, 4'b0000);
         chk("rst_no_fall", bus.fall, 4'b0000);
      end
      edges(1);
      chk("rst_db_commit", bus.db, 4'b1111);
      chk("rst_rise", bus.rise, 4'b1111);
      edges(1);
      chk("rst_rise_end", bus.rise, 4'b0000);
      chk("rst_db_hold", bus.db, 4'b1111);

      // Fall on bit 2
      drive(4'b1011);
      edges(5);
      chk("fall_before", bus.db, 4'b1111);
      edges(1);
      chk("fall_db", bus.db, 4'b1011);
      chk("fall_pulse", bus.fall, 4'b0100);
      chk("fall_no_rise", bus.rise, 4'b0000);
      edges(1);
      chk("fall_pulse_end", bus.fall, 4'b0000);

      drive(4'b0000);
      edges(10);
      chk("all_low", bus.db, 4'b0000);

      // Clean rise on bit 0
      drive(4'b0001);
      edges(5);
      chk("clean_before", bus.db, 4'b0000);
      edges(1);
      chk("clean_db", bus.db, 4'b0001);
      chk("clean_rise", bus.rise, 4'b0001);
      edges(1);
      chk("clean_rise_end", bus.rise, 4'b0000);

      // Three-cycle glitch on bit 1 is rejected
      drive(4'b0011);
      edges(3);
      drive(4'b0001);
      edges(10);
      chk("glitch3_db", bus.db, 4'b0001);

      // Four-cycle pulse is exactly enough to commit
      drive(4'b0011);
      edges(4);
      drive(4'b0001);
      edges(1);
      chk("pulse4_before", bus.db, 4'b0001);
      edges(1);
      chk("pulse4_db", bus.db, 4'b0011);
      chk("pulse4_rise", bus.rise, 4'b0010);
      edges(10);
      chk("pulse4_back", bus.db, 4'b0001);

      // Six-cycle hold on bit 1
      drive(4'b0011);
      edges(5);
      chk("hold6_before", bus.db, 4'b0001);
      edges(1);
      chk("hold6_db", bus.db, 4'b0011);
      chk("hold6_rise", bus.rise, 4'b0010);
      drive(4'b0001);
      edges(10);
      chk("hold6_back", bus.db, 4'b0001);

      // Reset mid-count on bit 3
      drive(4'b1001);
      edges(3);
      @(negedge clk);
      reset = 1'b1;
      edges(1);
      chk("midrst_db", bus.db, 4'b0000);
      chk("midrst_rise", bus.rise, 4'b0000);
      chk("midrst_fall", bus.fall, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      edges(5);
      chk("midrst_before", bus.db, 4'b0000);
      edges(1);
      chk("midrst_db_commit", bus.db, 4'b1001);
      chk("midrst_rise_commit", bus.rise, 4'b1001);

      // Simultaneous rise on bits 0 and 2
      drive(4'b0000);
      edges(10);
      chk("simul_idle", bus.db, 4'b0000);
      drive(4'b0101);
      edges(5);
      chk("simul_before", bus.db, 4'b0000);
      edges(1);
      chk("simul_db", bus.db, 4'b0101);
      chk("simul_rise", bus.rise, 4'b0101);
      edges(1);
      chk("simul_rise_end", bus.rise, 4'b0000);

      edges(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
